// File: rtl/logic_sweep_unit.sv
// Registered lane-wise evaluator for four 3-input Boolean functions, with a
// self-sweep engine that captures the truth table and checks it against a golden table.
module logic_sweep_unit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_x,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [7:0]       truth_table,
   output logic             pass
);

   typedef enum logic [1:0] {IDLE, SWEEP, CHECK} state_t;

   state_t     state;
   logic [2:0] idx;
   logic [1:0] mode_q;
   logic       mismatch;

   function automatic logic [WIDTH-1:0] eval_fn(input logic [1:0] m,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c);
      case (m)
         2'b00:   return a & (b | c);
         2'b01:   return a | (b & c);
         2'b10:   return a ^ (b | c);
         default: return (a & b) | (a & c) | (b & c);
      endcase
   endfunction

   function automatic logic [7:0] gold_fn(input logic [1:0] m);
      case (m)
         2'b00:   return 8'hE0;
         2'b01:   return 8'hF8;
         2'b10:   return 8'h1E;
         default: return 8'hE8;
      endcase
   endfunction

   // Every lane sees the same sweep point, so any disagreement with lane 0 is a lane fault.
   logic [WIDTH-1:0] sweep_res;
   logic             lane_diff;
   logic [7:0]       tt_next;

   always_comb begin
      // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
      tt_next   = truth_table;
      sweep_res = eval_fn(mode_q, {WIDTH{idx[2]}}, {WIDTH{idx[1]}}, {WIDTH{idx[0]}});
      lane_diff = (sweep_res != {WIDTH{sweep_res[0]}});
      tt_next[idx] = sweep_res[0];
   end

   // Gated by rst_n so the port reads 0 while reset is held.
   assign in_ready = rst_n && (state == IDLE);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= 3'd0;
         mode_q      <= 2'b00;
         mismatch    <= 1'b0;
         truth_table <= 8'h00;
         pass        <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
         out_x       <= '0;
      end else begin
         done      <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  out_valid <= 1'b1;
                  out_x     <= eval_fn(mode, in_a, in_b, in_c);
               end
               if (start) begin
                  state       <= SWEEP;
                  mode_q      <= mode;
                  idx         <= 3'd0;
                  truth_table <= 8'h00;
                  pass        <= 1'b0;
                  mismatch    <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            SWEEP: begin
               truth_table <= tt_next;
               mismatch    <= mismatch | lane_diff;
               idx         <= idx + 3'd1;
               // Verdict uses the table including this final write.
               if (idx == 3'd7) begin
                  state <= CHECK;
                  done  <= 1'b1;
                  pass  <= (tt_next == gold_fn(mode_q)) && !(mismatch || lane_diff);
               end
            end
            CHECK: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
